// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph patterns, error nibble and FSM encoding for the 7-segment reader
package seg7_pkg;

  // Patterns are gfedcba, active-low (bit0 = segment a).
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001001;

  localparam logic [3:0] ERR_NIBBLE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // True when exactly one anode line is driven low.
  function automatic logic one_low(input logic [7:0] an);
    logic [7:0] lo;
    lo = ~an;
    return (lo != 8'h00) && ((lo & (lo - 8'd1)) == 8'h00);
  endfunction

  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to hex nibble decoder
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_value,
  output logic       o_err
);

  always_comb begin
    o_value = ERR_NIBBLE;
    o_err   = 1'b0;
    case (i_pattern)
      GLYPH_0: o_value = 4'h0;
      GLYPH_1: o_value = 4'h1;
      GLYPH_2: o_value = 4'h2;
      GLYPH_3: o_value = 4'h3;
      GLYPH_4: o_value = 4'h4;
      GLYPH_5: o_value = 4'h5;
      GLYPH_6: o_value = 4'h6;
      GLYPH_7: o_value = 4'h7;
      GLYPH_8: o_value = 4'h8;
      GLYPH_9: o_value = 4'h9;
      GLYPH_A: o_value = 4'hA;
      default: o_err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - snoops a scanned 8-digit 7-segment display and rebuilds the shown digits
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1048575
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [6:0]  iSeg,
  input  logic [7:0]  iAn,
  output logic [31:0] oDigits,
  output logic [7:0]  oErr,
  output logic        oValid,
  output logic        oFrame
);

  localparam logic [3:0]  STABLE_N  = 4'(STABLE_CYCLES);
  localparam logic [19:0] TIMEOUT_N = 20'(TIMEOUT);

  logic [6:0]  r_seg;
  logic [7:0]  r_an;
  state_t      r_state;
  logic [6:0]  r_cap_seg;
  logic [7:0]  r_cap_an;
  logic [3:0]  r_cnt;
  logic [19:0] r_to;
  logic [7:0]  r_mask;
  logic [31:0] r_digits;
  logic [7:0]  r_err;
  logic        r_valid;
  logic        r_frame;

  state_t      w_state_next;
  logic        w_qual;
  logic        w_same;
  logic        w_start;
  logic        w_load;
  logic        w_inc;
  logic        w_latch;
  logic [2:0]  w_idx;
  logic [7:0]  w_bit;
  logic [7:0]  w_mask_set;
  logic [3:0]  w_value;
  logic        w_bad;
  logic [19:0] w_to_inc;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_seg <= 7'h7F;
      r_an  <= 8'hFF;
    end else begin
      r_seg <= iSeg;
      r_an  <= iAn;
    end
  end

  assign w_qual     = one_low(r_an);
  assign w_same     = (r_an == r_cap_an) && (r_seg == r_cap_seg);
  assign w_idx      = low_index(r_an);
  assign w_bit      = 8'd1 << w_idx;
  assign w_mask_set = r_mask | w_bit;
  assign w_to_inc   = (r_to == 20'hFFFFF) ? r_to : r_to + 20'd1;

  // A latch only happens when the live sample equals the captured one, so decode the live sample.
  seg7_pattern_decode u_decode (
    .i_pattern (r_seg),
    .o_value   (w_value),
    .o_err     (w_bad)
  );

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_inc        = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start = w_qual;
      end
      ST_SETTLE: begin
        if (!w_qual) begin
          w_state_next = ST_IDLE;
        end else if (w_same) begin
          if (r_cnt + 4'd1 >= STABLE_N) begin
            w_latch      = 1'b1;
            w_state_next = ST_HOLD;
          end else begin
            w_inc = 1'b1;
          end
        end else begin
          w_start = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!w_same) begin
          if (w_qual) w_start = 1'b1;
          else        w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Any new qualified sample begins a fresh settle, or latches at once when one sample suffices.
    if (w_start) begin
      w_load = 1'b1;
      if (STABLE_N <= 4'd1) begin
        w_latch      = 1'b1;
        w_state_next = ST_HOLD;
      end else begin
        w_state_next = ST_SETTLE;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state   <= ST_IDLE;
      r_cap_seg <= 7'h7F;
      r_cap_an  <= 8'hFF;
      r_cnt     <= 4'd0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_cap_seg <= r_seg;
        r_cap_an  <= r_an;
        r_cnt     <= 4'd1;
      end else if (w_inc) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_digits <= 32'hFFFFFFFF;
      r_err    <= 8'h00;
      r_mask   <= 8'h00;
      r_to     <= 20'd0;
      r_valid  <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (w_latch) begin
        r_digits[{w_idx, 2'b00} +: 4] <= w_value;
        r_err[w_idx]                  <= w_bad;
        r_to                          <= 20'd0;
        if (w_mask_set == 8'hFF) begin
          r_frame <= 1'b1;
          r_valid <= 1'b1;
          r_mask  <= 8'h00;
        end else begin
          r_mask <= w_mask_set;
        end
      end else begin
        r_to <= w_to_inc;
        if (w_to_inc >= TIMEOUT_N) begin
          r_valid <= 1'b0;
          r_mask  <= 8'h00;
        end
      end
    end
  end

  assign oDigits = r_digits;
  assign oErr    = r_err;
  assign oValid  = r_valid;
  assign oFrame  = r_frame;

endmodule
